// File: rtl/dc_mcl_scale_conf_sequencer.sv
// Sequencer between the width/height cyclic managers and the scaler configuration port.
// Define DC_MCL_SEQ_AUTO_STEP_EN to build the frame-counting auto-step generator.
module dc_mcl_scale_conf_sequencer #(
  parameter int SCR_SIZE_WIDTH = 12,
  parameter int STEP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      user_step,
  input  logic                      frame_start,
  input  logic [2:0]                sw_layer_0_scaling,
  input  logic [STEP_CNT_WIDTH-1:0] step_period,
  input  logic [SCR_SIZE_WIDTH-1:0] cur_width,
  input  logic [SCR_SIZE_WIDTH-1:0] cur_height,
  input  logic [SCR_SIZE_WIDTH-1:0] max_width,
  input  logic [SCR_SIZE_WIDTH-1:0] max_height,
  output logic                      step_valid,
  output logic                      conf_ready,
  output logic                      scl_conf_valid,
  input  logic                      scl_conf_ready,
  output logic [SCR_SIZE_WIDTH-1:0] scl_out_width,
  output logic [SCR_SIZE_WIDTH-1:0] scl_out_height,
  output logic [SCR_SIZE_WIDTH-1:0] scl_h_offset,
  output logic [SCR_SIZE_WIDTH-1:0] scl_v_offset,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, SETTLE, WAIT_FRAME, SEND, ACK} state_t;

  state_t                    state;
  logic                      cyclic_active;
  logic                      prev_active;
  logic                      restore_pend;
  logic                      restoring;
  logic                      auto_tick;
  logic                      step_req;
  logic                      w_over, h_over;
  logic [SCR_SIZE_WIDTH-1:0] cap_w, cap_h, cap_ho, cap_vo;
  logic [SCR_SIZE_WIDTH-1:0] sh_w, sh_h, sh_ho, sh_vo;

  assign cyclic_active = (sw_layer_0_scaling == 3'b100) || (sw_layer_0_scaling == 3'b101) ||
                         (sw_layer_0_scaling == 3'b110);
  assign step_req      = user_step | auto_tick;
  assign busy          = (state != IDLE);

  // Oversized dimensions clamp to the frame and sit flush at the origin.
  assign w_over = cur_width > max_width;
  assign h_over = cur_height > max_height;
  assign cap_w  = w_over ? max_width : cur_width;
  assign cap_h  = h_over ? max_height : cur_height;
  assign cap_ho = w_over ? '0 : (max_width - cur_width) >> 1;
  assign cap_vo = h_over ? '0 : (max_height - cur_height) >> 1;

`ifdef DC_MCL_SEQ_AUTO_STEP_EN
  logic [STEP_CNT_WIDTH-1:0] frame_cnt;

  assign auto_tick = (state == IDLE) && cyclic_active && frame_start &&
                     (step_period != '0) && (frame_cnt == step_period - STEP_CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_cnt <= '0;
    end else if (en) begin
      if ((state != IDLE) || !cyclic_active)
        frame_cnt <= '0;
      else if (frame_start && (step_period != '0))
        frame_cnt <= auto_tick ? '0 : frame_cnt + STEP_CNT_WIDTH'(1);
    end
  end
`else
  logic unused_step_period;
  assign unused_step_period = ^step_period;
  assign auto_tick          = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      prev_active    <= 1'b0;
      restore_pend   <= 1'b0;
      restoring      <= 1'b0;
      step_valid     <= 1'b0;
      conf_ready     <= 1'b0;
      scl_conf_valid <= 1'b0;
      sh_w           <= '0;
      sh_h           <= '0;
      sh_ho          <= '0;
      sh_vo          <= '0;
      scl_out_width  <= '0;
      scl_out_height <= '0;
      scl_h_offset   <= '0;
      scl_v_offset   <= '0;
    end else if (en) begin
      step_valid  <= 1'b0;
      conf_ready  <= 1'b0;
      prev_active <= cyclic_active;
      case (state)
        IDLE: begin
          if (restore_pend) begin
            sh_w         <= max_width;
            sh_h         <= max_height;
            sh_ho        <= '0;
            sh_vo        <= '0;
            restore_pend <= 1'b0;
            restoring    <= 1'b1;
            state        <= WAIT_FRAME;
          end else if (cyclic_active && step_req) begin
            step_valid <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (!cyclic_active) begin
            state <= IDLE;
          end else begin
            sh_w  <= cap_w;
            sh_h  <= cap_h;
            sh_ho <= cap_ho;
            sh_vo <= cap_vo;
            state <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          // A restore proceeds with the mode already off; only a step is abandoned.
          if (!cyclic_active && !restoring) begin
            state <= IDLE;
          end else if (frame_start) begin
            scl_conf_valid <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          if (scl_conf_ready) begin
            scl_out_width  <= sh_w;
            scl_out_height <= sh_h;
            scl_h_offset   <= sh_ho;
            scl_v_offset   <= sh_vo;
            scl_conf_valid <= 1'b0;
            conf_ready     <= 1'b1;
            state          <= ACK;
          end
        end
        ACK: begin
          restoring <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (prev_active && !cyclic_active)
        restore_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dc_mcl_scale_conf_sequencer.sv
// Directed, table-driven bench for dc_mcl_scale_conf_sequencer.
module tb_dc_mcl_scale_conf_sequencer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b1;
  logic        user_step = 1'b0;
  logic        frame_start = 1'b0;
  logic [2:0]  sw_layer_0_scaling = 3'b000;
  logic [7:0]  step_period = 8'd0;
  logic [11:0] cur_width = '0, cur_height = '0, max_width = '0, max_height = '0;
  logic        step_valid, conf_ready, scl_conf_valid, busy;
  logic        scl_conf_ready = 1'b0;
  logic [11:0] scl_out_width, scl_out_height, scl_h_offset, scl_v_offset;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dc_mcl_scale_conf_sequencer dut (
    .clk(clk), .nrst(nrst), .en(en), .user_step(user_step), .frame_start(frame_start),
    .sw_layer_0_scaling(sw_layer_0_scaling), .step_period(step_period),
    .cur_width(cur_width), .cur_height(cur_height), .max_width(max_width), .max_height(max_height),
    .step_valid(step_valid), .conf_ready(conf_ready), .scl_conf_valid(scl_conf_valid),
    .scl_conf_ready(scl_conf_ready), .scl_out_width(scl_out_width), .scl_out_height(scl_out_height),
    .scl_h_offset(scl_h_offset), .scl_v_offset(scl_v_offset), .busy(busy)
  );

  typedef struct {
    logic [11:0] cw, ch, mw, mh;
    logic [11:0] ew, eh, eho, evo;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [47:0] outs();
    return {scl_out_width, scl_out_height, scl_h_offset, scl_v_offset};
  endfunction

  task automatic start_step();
    user_step = 1'b1;
    tick();
    user_step = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic accept();
    scl_conf_ready = 1'b1;
    tick();
    scl_conf_ready = 1'b0;
  endtask

  initial begin
    logic [47:0] prev;
    vecs[0] = '{12'd640,  12'd360, 12'd1280, 12'd720, 12'd640,  12'd360, 12'd320, 12'd180};
    vecs[1] = '{12'd1300, 12'd720, 12'd1280, 12'd720, 12'd1280, 12'd720, 12'd0,   12'd0};
    vecs[2] = '{12'd1000, 12'd700, 12'd1280, 12'd720, 12'd1000, 12'd700, 12'd140, 12'd10};
    vecs[3] = '{12'd641,  12'd361, 12'd1280, 12'd720, 12'd641,  12'd361, 12'd319, 12'd179};
    vecs[4] = '{12'd0,    12'd800, 12'd1280, 12'd720, 12'd0,    12'd720, 12'd640, 12'd0};
    vecs[5] = '{12'd1280, 12'd720, 12'd1280, 12'd720, 12'd1280, 12'd720, 12'd0,   12'd0};

    tick();
    tick();
    check("reset_ctrl", {step_valid, conf_ready, scl_conf_valid, busy}, 4'b0000);
    check("reset_outs", outs(), 48'd0);
    nrst = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);

    // One full step per table row.
    sw_layer_0_scaling = 3'b110;
    for (int i = 0; i < 6; i++) begin
      cur_width = vecs[i].cw; cur_height = vecs[i].ch;
      max_width = vecs[i].mw; max_height = vecs[i].mh;
      start_step();
      check("step_valid_pulse", step_valid, 1'b1);
      frame_start = 1'b1;            // lands in SETTLE and must be ignored
      tick();
      frame_start = 1'b0;
      check("step_valid_drop", step_valid, 1'b0);
      tick();
      check("no_valid_before_frame", scl_conf_valid, 1'b0);
      pulse_frame();
      check("conf_valid", scl_conf_valid, 1'b1);
      accept();
      check("row_outs", outs(), {vecs[i].ew, vecs[i].eh, vecs[i].eho, vecs[i].evo});
      check("conf_ready_pulse", {conf_ready, scl_conf_valid}, 2'b10);
      tick();
      check("conf_ready_low", {conf_ready, busy}, 2'b00);
      $display("row %0d: cur %0dx%0d max %0dx%0d -> %0dx%0d off %0d/%0d", i,
               vecs[i].cw, vecs[i].ch, vecs[i].mw, vecs[i].mh,
               scl_out_width, scl_out_height, scl_h_offset, scl_v_offset);
    end

    // Scaler stalls in SEND; a user_step there is dropped.
    prev = outs();
    cur_width = 12'd320; cur_height = 12'd240; max_width = 12'd1280; max_height = 12'd720;
    start_step();
    tick();
    pulse_frame();
    for (int i = 0; i < 5; i++) begin
      user_step = (i == 2);
      tick();
      user_step = 1'b0;
      check("stall_valid", scl_conf_valid, 1'b1);
      check("stall_outs", outs(), prev);
      check("stall_no_step", step_valid, 1'b0);
    end
    accept();
    check("stall_accept_outs", outs(), {12'd320, 12'd240, 12'd480, 12'd240});
    tick();
    check("stall_no_second_step", {step_valid, busy}, 2'b00);
    $display("stall: accepted %0dx%0d off %0d/%0d", scl_out_width, scl_out_height,
             scl_h_offset, scl_v_offset);

    // Enable low freezes a pending pulse.
    cur_width = 12'd640; cur_height = 12'd360;
    start_step();
    en = 1'b0;
    tick();
    tick();
    check("freeze_pulse", {step_valid, busy}, 2'b11);
    en = 1'b1;
    tick();
    check("unfreeze_drop", step_valid, 1'b0);
    pulse_frame();
    accept();
    check("freeze_outs", outs(), {12'd640, 12'd360, 12'd320, 12'd180});
    tick();
    $display("freeze: step completed after en restored");

    // Mode exit in WAIT_FRAME, then full-size restore.
    cur_width = 12'd800; cur_height = 12'd600;
    start_step();
    tick();
    sw_layer_0_scaling = 3'b000;
    tick();
    check("exit_to_idle", {busy, scl_conf_valid}, 2'b00);
    tick();
    check("restore_wait", {busy, scl_conf_valid, step_valid}, 3'b100);
    pulse_frame();
    check("restore_valid", scl_conf_valid, 1'b1);
    accept();
    check("restore_outs", outs(), {12'd1280, 12'd720, 12'd0, 12'd0});
    check("restore_ack", conf_ready, 1'b1);
    tick();
    check("restore_done", busy, 1'b0);
    $display("restore: %0dx%0d off %0d/%0d", scl_out_width, scl_out_height,
             scl_h_offset, scl_v_offset);

    // Auto-step from frame count.
    sw_layer_0_scaling = 3'b100;
    step_period = 8'd3;
    tick();
`ifdef DC_MCL_SEQ_AUTO_STEP_EN
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 3; k++) begin
        pulse_frame();
        check("auto_step", step_valid, (k == 3));
        tick();
      end
      pulse_frame();
      accept();
      tick();
      check("auto_idle", busy, 1'b0);
      $display("auto round %0d: step on 3rd frame", r);
    end
`else
    for (int k = 0; k < 6; k++) begin
      pulse_frame();
      check("no_auto_step", step_valid, 1'b0);
    end
    $display("auto: absent, no steps from frames");
`endif
    step_period = 8'd0;
    for (int k = 0; k < 4; k++) begin
      pulse_frame();
      check("period0_no_step", step_valid, 1'b0);
    end

    // Asynchronous reset while in SEND.
    sw_layer_0_scaling = 3'b110;
    start_step();
    tick();
    pulse_frame();
    check("pre_reset_send", scl_conf_valid, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    check("async_reset_ctrl", {step_valid, conf_ready, scl_conf_valid, busy}, 4'b0000);
    check("async_reset_outs", outs(), 48'd0);
    #3;
    nrst = 1'b1;
    tick();
    check("post_reset_idle", {busy, scl_conf_valid}, 2'b00);
    $display("reset: cleared in SEND");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dc_mcl_scale_conf_sequencer.md
# dc_mcl_scale_conf_sequencer

Sequencer in the main control logic between the width/height cyclic managers and the scaler datapath configuration port. It generates step requests to both managers, captures their updated dimensions, and computes centring offsets. It presents one scaler configuration per step through a valid/ready handshake aligned to a frame boundary, then returns a one-cycle `conf_ready` acknowledge to the managers.

## Interface
- `SCR_SIZE_WIDTH`, 12: width of all dimension/offset buses.
- `STEP_CNT_WIDTH`, 8: width of the auto-step frame counter and `step_period`.
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `en` in 1: global enable; when low, all registers hold.
- `user_step` in 1: single-cycle user step request (debounced upstream).
- `frame_start` in 1: single-cycle pulse at start of vertical blank.
- `sw_layer_0_scaling` in 3: scaling mode switch.
- `step_period` in STEP_CNT_WIDTH: auto-step period in frames; 0 disables auto-step.
- `cur_width`, `cur_height` in SCR_SIZE_WIDTH: `curr_dim` from the width/height managers.
- `max_width`, `max_height` in SCR_SIZE_WIDTH: output frame size.
- `step_valid` out 1: one-cycle pulse to both managers' `user_int_valid`.
- `conf_ready` out 1: one-cycle pulse to both managers after scaler acceptance.
- `scl_conf_valid` out 1: configuration valid to scaler.
- `scl_conf_ready` in 1: scaler accepts configuration.
- `scl_out_width`, `scl_out_height` out SCR_SIZE_WIDTH: committed scaled size.
- `scl_h_offset`, `scl_v_offset` out SCR_SIZE_WIDTH: committed centring offsets.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `cyclic_active` = `sw_layer_0_scaling` ∈ {100, 101, 110}.
- Step request = `user_step` OR auto-step tick, accepted only in IDLE with `cyclic_active`. Requests in any other state are dropped.
- FSM states:
  - IDLE: on an accepted request, pulse `step_valid` and go to SETTLE.
  - SETTLE: lasts one cycle, so manager `curr_dim` updates. Capture dimensions and offsets into shadow registers, then go to WAIT_FRAME.
  - WAIT_FRAME: on `frame_start`, go to SEND.
  - SEND: `scl_conf_valid`=1. Hold until `scl_conf_ready`; on that cycle copy shadow registers to `scl_*` outputs and go to ACK.
  - ACK: pulse `conf_ready` for one cycle, then go to IDLE.
- Offset arithmetic:
  - `h_off` = (`max_width` − `cur_width`) >> 1; vertical offset likewise.
  - If `cur_width` > `max_width`, width clamps to `max_width` and offset is 0; vertical likewise.
  - All arithmetic is unsigned at SCR_SIZE_WIDTH.
- Mode exit: if `cyclic_active` falls in SETTLE or WAIT_FRAME, go to IDLE without a handshake. In SEND, the handshake completes; valid is never withdrawn.
- Full-size restore: when `cyclic_active` is low for a cycle after being high, a restore request is latched. The restore is serviced from IDLE as WAIT_FRAME→SEND→ACK with shadow = max dims and offsets 0, and no `step_valid`.
- Auto-step counter:
  - Increments on `frame_start` in IDLE with `cyclic_active` and `step_period`≠0.
  - On reaching `step_period`−1 it raises a tick and clears to 0.
  - It clears whenever the FSM leaves IDLE or `cyclic_active` is low.
- Simultaneous `user_step` and auto tick count as one request.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Counter, shadow registers and restore flag 0.
- `step_valid` is registered: it asserts the cycle after the request is sampled.
- Capture happens on the cycle following `step_valid`.
- `frame_start` during SETTLE is ignored; the next frame is used.
- Minimum latency, with `frame_start` and `scl_conf_ready` present as early as possible:
  - request → `step_valid` in 1 cycle;
  - `scl_conf_valid` 3 cycles after request;
  - `conf_ready` 1 cycle after acceptance.
- `scl_*` outputs change only on the acceptance edge and are stable otherwise.
- `conf_ready` is low in the cycle after its pulse, which satisfies the managers' `!conf_ready` requirement for the next step.
- `en`=0 freezes all state, including pulses, which stay asserted.
- Reset mid-operation returns all state to reset values immediately.

## Configuration
- `DC_MCL_SEQ_AUTO_STEP_EN` defined: the frame counter and auto-step tick are built.
- Macro absent: no counter logic; `step_period` is unused and steps come only from `user_step`.

## Test plan
- Reset, mode 110, `max` 1280×720, managers return 640×360; `user_step` → `step_valid` 1 cycle later. At the next `frame_start`, `scl_conf_valid`; ready → outputs 640×360, offsets 320/180, then a single `conf_ready` pulse.
- `scl_conf_ready` held low 5 cycles in SEND → valid held and outputs unchanged. A `user_step` during this time is dropped, with no second `step_valid`.
- Mode 110→000 during WAIT_FRAME → FSM to IDLE, no valid. The next `frame_start` delivers the restore config: 1280×720, offsets 0.
- `cur_width`=1300 > `max_width`=1280 → width 1280, h_offset 0.
- With macro, `step_period`=3 and mode 100 → `step_valid` every 3rd `frame_start` while IDLE. `step_period`=0 → none.
- Assert `nrst` while in SEND → all outputs 0 asynchronously, and the FSM is IDLE after release.
